// File: rtl/collision_query_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : collision_query_arbiter_if
// Brief    : Requester/checker bundle for the maze collision query arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface collision_query_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*10-1:0] qx;
    logic [NREQ*9-1:0]  qy;
    logic [NREQ*2-1:0]  qdir;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic               rsp_blocked;
    logic               chk_valid;
    logic [9:0]         chk_x;
    logic [8:0]         chk_y;
    logic [1:0]         chk_dir;
    logic               chk_done;
    logic               chk_blocked;
    logic               timeout_err;

    modport slave (
        input  req, qx, qy, qdir, chk_done, chk_blocked,
        output gnt, rsp_valid, rsp_blocked, chk_valid, chk_x, chk_y, chk_dir,
               timeout_err
    );

    modport master (
        output req, qx, qy, qdir, chk_done, chk_blocked,
        input  gnt, rsp_valid, rsp_blocked, chk_valid, chk_x, chk_y, chk_dir,
               timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/collision_query_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : collision_query_arbiter
// Brief    : Round-robin sharing of the wall-collision checker between
//            Pac-Man (requester 0) and the ghosts, with a hung-checker timeout.
//            Define PAC_PRIORITY_EN to give requester 0 absolute priority.
// Revision : 1.0  initial release
// ============================================================================
module collision_query_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    collision_query_arbiter_if.slave  bus
);
    localparam int       c_IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam bit [7:0] c_TLAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [c_IW-1:0] r_win;
    logic [c_IW-1:0] r_last;
    logic [c_IW-1:0] w_pick;
    logic            w_found;
    int              w_idx;
    logic [7:0]      r_timer;
    logic            r_blocked;
    logic            r_terr;
    logic [9:0]      r_cx;
    logic [8:0]      r_cy;
    logic [1:0]      r_cd;
    logic [NREQ-1:0] w_onehot;
    logic [NREQ-1:0] w_gnt;
    logic [NREQ-1:0] w_rv;
    logic            w_rb;
    logic            w_cv;

    // Cyclic search for the first requester after the last one served.
    always_comb begin
        w_pick  = r_last;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_last) + k) % NREQ;
            if (!w_found && bus.req[w_idx]) begin
                w_pick  = c_IW'(w_idx);
                w_found = 1'b1;
            end
        end
`ifdef PAC_PRIORITY_EN
        if (bus.req[0]) begin
            w_pick = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_onehot = NREQ'(1) << r_win;

    always_comb begin
        w_next = r_state;
        w_gnt  = '0;
        w_rv   = '0;
        w_rb   = 1'b0;
        w_cv   = 1'b0;
        case (r_state)
            S_IDLE:  if (|bus.req) w_next = S_ISSUE;
            S_ISSUE: begin
                w_gnt  = w_onehot;
                w_cv   = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT:  if (bus.chk_done || (r_timer == c_TLAST)) w_next = S_RESP;
            S_RESP:  begin
                w_rv   = w_onehot;
                w_rb   = r_blocked;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win     <= '0;
            r_last    <= c_IW'(NREQ - 1);
            r_timer   <= '0;
            r_blocked <= 1'b0;
            r_terr    <= 1'b0;
            r_cx      <= '0;
            r_cy      <= '0;
            r_cd      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|bus.req) begin
                        r_win <= w_pick;
                        r_cx  <= bus.qx[w_pick*10 +: 10];
                        r_cy  <= bus.qy[w_pick*9 +: 9];
                        r_cd  <= bus.qdir[w_pick*2 +: 2];
                    end
                end
                S_ISSUE: r_timer <= '0;
                S_WAIT: begin
                    // A real answer on the final timer cycle beats the forced block.
                    if (bus.chk_done) begin
                        r_blocked <= bus.chk_blocked;
                    end else if (r_timer == c_TLAST) begin
                        r_blocked <= 1'b1;
                        r_terr    <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_RESP: begin
`ifdef PAC_PRIORITY_EN
                    if (r_win != '0) begin
                        r_last <= r_win;
                    end
`else
                    r_last <= r_win;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt         = w_gnt;
    assign bus.chk_valid   = w_cv;
    assign bus.rsp_valid   = w_rv;
    assign bus.rsp_blocked = w_rb;
    assign bus.chk_x       = r_cx;
    assign bus.chk_y       = r_cy;
    assign bus.chk_dir     = r_cd;
    assign bus.timeout_err = r_terr;
endmodule
`default_nettype wire

// File: tb/tb_collision_query_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_collision_query_arbiter
// Brief    : Directed bench for collision_query_arbiter with a timestamp-based
//            reference model and hand-computed literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_collision_query_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    collision_query_arbiter_if #(.NREQ(NREQ)) bus ();

    collision_query_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int last);
`ifdef PAC_PRIORITY_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return last;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] g);
        for (int i = 0; i < NREQ; i++) if (g[i]) return i;
        return -1;
    endfunction

    // Reference model: tracks grant/response cycle numbers, not FSM states.
    int cyc, m_free, m_gcyc, m_rcyc, m_win, m_last;
    bit m_busy, m_timed;
    logic m_rb;
    logic [NREQ-1:0] e_gnt, e_rv;
    logic e_rb, e_cv, e_terr;
    logic [9:0] e_cx;
    logic [8:0] e_cy;
    logic [1:0] e_cd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; m_free = 0; m_busy = 0; m_timed = 0; m_rb = 0;
            m_gcyc = 0; m_rcyc = 0; m_win = 0; m_last = NREQ - 1;
            e_gnt = '0; e_rv = '0; e_rb = 0; e_cv = 0; e_terr = 0;
            e_cx = '0; e_cy = '0; e_cd = '0;
        end else begin
            if (!m_busy && cyc >= m_free && bus.req != '0) begin
                m_win  = pick(bus.req, m_last);
                m_busy = 1; m_gcyc = cyc + 1; m_rcyc = m_gcyc + TIMEOUT + 1;
                m_rb = 1; m_timed = 1;
                e_cx = bus.qx[m_win*10 +: 10];
                e_cy = bus.qy[m_win*9 +: 9];
                e_cd = bus.qdir[m_win*2 +: 2];
            end else if (m_busy && cyc > m_gcyc && cyc < m_rcyc && bus.chk_done) begin
                m_rcyc = cyc + 1; m_rb = bus.chk_blocked; m_timed = 0;
            end
            e_gnt = (m_busy && cyc + 1 == m_gcyc) ? (NREQ'(1) << m_win) : '0;
            e_cv  = m_busy && (cyc + 1 == m_gcyc);
            if (m_busy && cyc + 1 == m_rcyc) begin
                e_rv = NREQ'(1) << m_win;
                e_rb = m_rb;
                if (m_timed) e_terr = 1;
`ifdef PAC_PRIORITY_EN
                if (m_win != 0) m_last = m_win;
`else
                m_last = m_win;
`endif
                m_busy = 0; m_free = m_rcyc + 1;
            end else begin
                e_rv = '0; e_rb = 0;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cycle_outputs",
                {bus.gnt, bus.rsp_valid, bus.rsp_blocked, bus.chk_valid,
                 bus.chk_x, bus.chk_y, bus.chk_dir, bus.timeout_err},
                {e_gnt, e_rv, e_rb, e_cv, e_cx, e_cy, e_cd, e_terr});
            chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
        end
    end

    task automatic wait_cv(output bit ok, output logic [NREQ-1:0] g);
        ok = 0; g = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.chk_valid) begin ok = 1; g = bus.gnt; end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL wait_cv: got no chk_valid expected one within 20 cycles");
        end
    endtask

    // Entered at the negedge of the chk_valid cycle; d<=0 means never answer.
    task automatic answer_and_wait(input int d, input bit blk, output int lat,
                                   output logic rb, output logic [NREQ-1:0] rv);
        bit seen;
        seen = 0; lat = -1; rb = 0; rv = '0;
        for (int i = 1; i <= TIMEOUT + 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) begin
                seen = 1; lat = i; rb = bus.rsp_blocked; rv = bus.rsp_valid;
            end
            bus.chk_done    = (i == d);
            bus.chk_blocked = blk;
        end
        bus.chk_done = 0; bus.chk_blocked = 0;
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL wait_rsp: got no rsp_valid expected one within %0d cycles", TIMEOUT + 20);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #2 rst = 1;
        repeat (2) @(negedge clk);
        #2 rst = 0;
    endtask

    bit ok;
    logic [NREQ-1:0] g, rv;
    logic rb;
    int lat;
    int order[8];
    int exp_order[8];

    initial begin
        bus.req = '0; bus.qx = '0; bus.qy = '0; bus.qdir = '0;
        bus.chk_done = 0; bus.chk_blocked = 0;
        #1 rst = 1;
        #1 started = 1;
        repeat (2) @(negedge clk);
        chk("reset_gnt", 32'(bus.gnt), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_timeout_err", 32'(bus.timeout_err), 32'd0);
        #2 rst = 0;

        // Single Pac-Man query, checker answers blocked two cycles later.
        @(negedge clk);
        bus.qx = {10'd11, 10'd22, 10'd33, 10'd200};
        bus.qy = {9'd44, 9'd55, 9'd66, 9'd146};
        bus.qdir = {2'b11, 2'b10, 2'b00, 2'b01};
        bus.req = 4'b0001;
        wait_cv(ok, g);
        bus.req = '0;
        chk("t1_gnt", 32'(g), 32'h1);
        chk("t1_chk_x", 32'(bus.chk_x), 32'd200);
        chk("t1_chk_y", 32'(bus.chk_y), 32'd146);
        chk("t1_chk_dir", 32'(bus.chk_dir), 32'd1);
        answer_and_wait(2, 1, lat, rb, rv);
        chk("t1_rsp_lat", 32'(lat), 32'd3);
        chk("t1_rsp_valid", 32'(rv), 32'h1);
        chk("t1_rsp_blocked", 32'(rb), 32'd1);
        @(negedge clk);
        chk("t1_rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);

        // All requesting: fairness rotation.
        do_reset();
        bus.req = 4'b1111;
        for (int q = 0; q < 8; q++) begin
            wait_cv(ok, g);
            order[q] = idx_of(g);
            answer_and_wait(1, 0, lat, rb, rv);
            if (q == 0) chk("t2_rsp_lat", 32'(lat), 32'd2);
        end
        bus.req = '0;
`ifdef PAC_PRIORITY_EN
        exp_order = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        for (int q = 0; q < 8; q++) chk($sformatf("t2_order%0d", q), 32'(order[q]), 32'(exp_order[q]));

        // Hung checker: forced blocked after the timeout.
        @(negedge clk);
        bus.req = 4'b0100;
        wait_cv(ok, g);
        bus.req = '0;
        chk("t3_gnt", 32'(g), 32'h4);
        answer_and_wait(0, 0, lat, rb, rv);
        chk("t3_rsp_lat", 32'(lat), 32'(TIMEOUT + 1));
        chk("t3_rsp_valid", 32'(rv), 32'h4);
        chk("t3_rsp_blocked", 32'(rb), 32'd1);
        chk("t3_timeout_err", 32'(bus.timeout_err), 32'd1);

        // Normal query afterwards: sticky error flag survives.
        @(negedge clk);
        bus.req = 4'b0010;
        wait_cv(ok, g);
        bus.req = '0;
        chk("t4_gnt", 32'(g), 32'h2);
        answer_and_wait(3, 0, lat, rb, rv);
        chk("t4_rsp_lat", 32'(lat), 32'd4);
        chk("t4_rsp_blocked", 32'(rb), 32'd0);
        chk("t4_timeout_err", 32'(bus.timeout_err), 32'd1);

        // chk_done noise during IDLE and ISSUE is ignored.
        @(negedge clk);
        bus.chk_done = 1; bus.chk_blocked = 1;
        repeat (2) @(negedge clk);
        chk("t5_idle_no_rsp", 32'(bus.rsp_valid), 32'd0);
        bus.req = 4'b1000;
        @(negedge clk);
        chk("t5_gnt", 32'(bus.gnt), 32'h8);
        bus.req = '0;
        answer_and_wait(4, 0, lat, rb, rv);
        chk("t5_rsp_lat", 32'(lat), 32'd5);
        chk("t5_rsp_blocked", 32'(rb), 32'd0);

        // Reset while waiting on requester 2.
        @(negedge clk);
        bus.req = 4'b0100;
        wait_cv(ok, g);
        bus.req = '0;
        chk("t6_gnt", 32'(g), 32'h4);
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("t6_rst_outputs", {bus.gnt, bus.rsp_valid, bus.rsp_blocked, bus.chk_valid,
                               bus.chk_x, bus.chk_y, bus.chk_dir, bus.timeout_err}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        #2 rst = 0;
        bus.req = 4'b1111;
        wait_cv(ok, g);
        bus.req = '0;
        chk("t6_next_gnt", 32'(g), 32'h1);
        answer_and_wait(1, 1, lat, rb, rv);
        chk("t6_rsp_valid", 32'(rv), 32'h1);

`ifdef PAC_PRIORITY_EN
        bus.req = 4'b1111;
        for (int q = 0; q < 3; q++) begin
            wait_cv(ok, g);
            chk($sformatf("t7_pac%0d", q), 32'(g), 32'h1);
            answer_and_wait(1, 0, lat, rb, rv);
        end
        bus.req = 4'b1110;
        exp_order = '{1, 2, 3, 1, 0, 0, 0, 0};
        for (int q = 0; q < 4; q++) begin
            wait_cv(ok, g);
            chk($sformatf("t7_ghost%0d", q), 32'(idx_of(g)), 32'(exp_order[q]));
            answer_and_wait(1, 0, lat, rb, rv);
        end
        bus.req = '0;
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/collision_query_arbiter.md
Name: collision_query_arbiter

Overview:
- Shares the single maze wall-collision checker between Pac-Man and the ghosts.
- Each requester submits a query (position plus intended direction). The block picks one requester round-robin, forwards its query to the checker, waits for the answer and returns the blocked/free result to that requester only.
- A timeout guard stops a hung checker from freezing sprite movement.

Parameters:
- NREQ, 4: number of requesters; index 0 = Pac-Man, 1..NREQ-1 = ghosts.
- TIMEOUT, 16: maximum cycles spent in WAIT before a forced "blocked" answer; must be 2..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester query request; held high until its gnt bit pulses
- qx  in  NREQ*10  packed X positions; requester i uses bits [i*10+9:i*10]
- qy  in  NREQ*9  packed Y positions; requester i uses bits [i*9+8:i*9]
- qdir  in  NREQ*2  packed directions: 00 up, 01 down, 10 left, 11 right
- gnt  out  NREQ  one-hot, one-cycle pulse: query accepted
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: result ready for that requester
- rsp_blocked  out  1  result; meaningful only while rsp_valid is non-zero; 1 = wall
- chk_valid  out  1  one-cycle pulse: query presented to the checker
- chk_x  out  10  query X to checker, held stable from ISSUE through WAIT
- chk_y  out  9  query Y to checker, held stable from ISSUE through WAIT
- chk_dir  out  2  query direction to checker, held stable from ISSUE through WAIT
- chk_done  in  1  checker answer strobe; sampled only in WAIT
- chk_blocked  in  1  checker answer, valid with chk_done
- timeout_err  out  1  sticky flag: a timeout has occurred since reset

Behaviour:
- Reset (async, rst=1): state IDLE, all outputs 0, last_grant = NREQ-1, so requester 0 has first priority.
- States are IDLE, ISSUE, WAIT and RESP.
- IDLE, req == 0: stay in IDLE.
- IDLE, req != 0:
  - Winner = first set bit of req, searching upward cyclically from last_grant+1.
  - Latch the winner index and that requester's qx/qy/qdir slice into chk_x/chk_y/chk_dir.
  - Next state ISSUE.
- ISSUE, one cycle:
  - gnt[winner] = 1 and chk_valid = 1.
  - Clear the wait timer; next state WAIT.
- WAIT, each cycle:
  - If chk_done = 1: latch chk_blocked and go to RESP.
  - Else if timer == TIMEOUT-1: force blocked = 1, set timeout_err, go to RESP.
  - Else: timer += 1.
  - chk_done in any state other than WAIT is ignored.
- RESP, one cycle:
  - rsp_valid[winner] = 1 and rsp_blocked = latched value.
  - last_grant = winner; next state IDLE.
- Latency:
  - req sampled at edge n gives gnt and chk_valid in cycle n+1.
  - chk_done sampled at edge k gives rsp_valid in cycle k+1.
  - The arbiter re-enters IDLE at k+2; the next grant appears at k+3 at earliest.
- Only one query is outstanding at a time.
- req bits that change while the block is not in IDLE have no effect until IDLE.
- A requester that drops req before being granted is simply skipped.
- The winner's req may stay high after gnt; it re-arbitrates normally in IDLE, so a continuously requesting single requester is served back-to-back.
- Fairness: with all req bits high, grants rotate 0,1,2,…,NREQ-1,0,…
- timeout_err clears only on rst.
- rsp_blocked returns to 0 outside RESP.
- Reset asserted mid-query: the query is aborted, no rsp_valid pulse, state IDLE.

Optional Feature:
- Macro: PAC_PRIORITY_EN.
- Defined: in IDLE, if req[0] = 1, requester 0 (Pac-Man) wins regardless of last_grant. Ghosts keep round-robin among themselves; last_grant updates only on ghost grants.
- Undefined: pure round-robin across all NREQ requesters.

Test Plan:
- Reset, then req=0001, qx[9:0]=200, qy[8:0]=146, qdir[1:0]=01; checker answers done=1 and blocked=1 two cycles after chk_valid -> gnt=0001 one cycle; chk_x=200, chk_y=146, chk_dir=01; rsp_valid=0001 with rsp_blocked=1 exactly one cycle.
- Hold req=1111 over 8 queries, checker answers with a 1-cycle delay and blocked=0 -> grant order 0,1,2,3,0,1,2,3; never two gnt bits high at once.
- req=0100 and chk_done never asserted -> rsp_valid=0100 with rsp_blocked=1 exactly TIMEOUT+1 cycles after chk_valid; timeout_err=1 and stays 1 through a following normal query.
- Pulse chk_done during IDLE and ISSUE -> no effect; the response is taken only from chk_done in WAIT.
- Assert rst during WAIT for requester 2 -> all outputs 0 immediately; no rsp_valid; the next grant with req=1111 goes to requester 0.
- With PAC_PRIORITY_EN defined, req=1111 held -> grants 0,0,0… Dropping req[0] -> ghosts alternate 1,2,3,1.
